// File: rtl/mul_share_ctrl.sv
// Shares one sequential shift-add multiplier between NREQ requesters: arbitrate, start, wait N cycles, return product.
// Define MUL_SHARE_RR_EN for round-robin arbitration; otherwise the lowest requesting index wins.
//
// state | meaning
// IDLE  | waiting for any req, winner latched on exit
// START | gnt and mul_start pulsed, counter cleared
// RUN   | multiplier accumulating, counter counts to N
// DONE  | done pulsed, product held on y_out
module mul_share_ctrl #(
  parameter int N    = 2,
  parameter int NREQ = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_i,
  input  logic [NREQ*N-1:0]   a_in_i,
  input  logic [NREQ*N-1:0]   b_in_i,
  output logic [NREQ-1:0]     gnt_o,
  output logic [NREQ-1:0]     done_o,
  output logic [2*N-1:0]      y_out_o,
  output logic                busy_o,
  output logic                mul_start_o,
  output logic [N-1:0]        mul_a_o,
  output logic [N-1:0]        mul_b_o,
  input  logic [2*N-1:0]      mul_y_i
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(N + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DONE} state_t;

  state_t            state_q;
  logic [IW-1:0]     owner_q;
  logic [IW-1:0]     win_d;
  logic [CW-1:0]     cnt_q;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   done_q;
  logic [2*N-1:0]    y_q;
  logic              busy_q;
  logic              mul_start_q;
  logic [N-1:0]      mul_a_q;
  logic [N-1:0]      mul_b_q;

`ifdef MUL_SHARE_RR_EN
  logic [IW-1:0]     ptr_q;
  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;

  // Rotate so bit 0 is the pointer position; lowest set bit is then the next in turn.
  assign req_dbl = {req_i, req_i} >> ptr_q;
  assign req_rot = req_dbl[NREQ-1:0];

  always_comb begin
    int sum;
    win_d = '0;
    sum   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        sum = int'(ptr_q) + k;
        if (sum >= NREQ) sum = sum - NREQ;
        win_d = IW'(sum);
      end
    end
  end
`else
  always_comb begin
    win_d = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_i[k]) win_d = IW'(k);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      y_q         <= '0;
      busy_q      <= 1'b0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
`ifdef MUL_SHARE_RR_EN
      ptr_q       <= '0;
`endif
    end else begin
      gnt_q       <= '0;
      done_q      <= '0;
      mul_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|req_i) begin
            owner_q     <= win_d;
            mul_a_q     <= a_in_i[int'(win_d)*N +: N];
            mul_b_q     <= b_in_i[int'(win_d)*N +: N];
            gnt_q       <= NREQ'(1) << win_d;
            mul_start_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_START;
          end
        end
        S_START: begin
          cnt_q   <= '0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (cnt_q == CW'(N)) begin
            y_q     <= mul_y_i;
            done_q  <= NREQ'(1) << owner_q;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
`ifdef MUL_SHARE_RR_EN
          if (owner_q == IW'(NREQ - 1)) ptr_q <= '0;
          else                          ptr_q <= owner_q + IW'(1);
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign y_out_o     = y_q;
  assign busy_o      = busy_q;
  assign mul_start_o = mul_start_q;
  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;

endmodule
